// File: rtl/wb_bus_scheduler.sv
// rtl/wb_bus_scheduler.sv - round-robin N-master Wishbone arbiter onto one slave port.
// Optional watchdog (counter, ABORT/RELEASE states) enabled by WB_BUS_SCHEDULER_WATCHDOG_EN.
module wb_bus_scheduler #(
    parameter int N       = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N-1:0]      m_cyc_i,
    input  logic [N-1:0]      m_stb_i,
    input  logic [N-1:0]      m_we_i,
    input  logic [N*AW-1:0]   m_adr_i,
    input  logic [N*DW-1:0]   m_dat_i,
    input  logic [N*DW/8-1:0] m_sel_i,
    output logic [N-1:0]      m_ack_o,
    output logic [N-1:0]      m_err_o,
    output logic [DW-1:0]     m_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic [DW-1:0]     s_dat_i,
    output logic [N-1:0]      gnt_o,
    output logic              busy_o,
    output logic              timeout_o
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = DW / 8;

`ifdef WB_BUS_SCHEDULER_WATCHDOG_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2, RELEASE = 2'd3} state_t;
    logic [15:0] wd_cnt;
    logic        stall;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;
`endif

    state_t        state;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] next_idx;
    logic [IW:0]   cand_sum;
    logic [IW-1:0] cand;
    logic          found;
    logic          act;

    // Search from last_grant+1 with wrap; i == N revisits last_grant so it wins only when alone.
    always_comb begin
        next_idx = last_grant;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 1; i <= N; i++) begin
            cand_sum = {1'b0, last_grant} + (IW+1)'(i);
            if (cand_sum >= (IW+1)'(N)) cand_sum = cand_sum - (IW+1)'(N);
            cand = cand_sum[IW-1:0];
            if (!found && m_cyc_i[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

    assign act     = (state == BUSY) && m_cyc_i[gnt_idx];
    assign s_cyc_o = act;
    assign s_stb_o = act && m_stb_i[gnt_idx];
    assign s_we_o  = act && m_we_i[gnt_idx];
    assign s_adr_o = act ? m_adr_i[gnt_idx*AW +: AW] : '0;
    assign s_dat_o = act ? m_dat_i[gnt_idx*DW +: DW] : '0;
    assign s_sel_o = act ? m_sel_i[gnt_idx*SW +: SW] : '0;
    assign m_dat_o = s_dat_i;

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        if (state == BUSY) begin
            m_ack_o[gnt_idx] = s_ack_i;
            m_err_o[gnt_idx] = s_err_i;
        end
`ifdef WB_BUS_SCHEDULER_WATCHDOG_EN
        if (state == ABORT) m_err_o[gnt_idx] = 1'b1;
`endif
    end

`ifdef WB_BUS_SCHEDULER_WATCHDOG_EN
    assign stall     = s_stb_o && !s_ack_i && !s_err_i;
    assign timeout_o = (state == ABORT);
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            gnt_idx    <= '0;
            last_grant <= IW'(N-1);
            gnt_o      <= '0;
            busy_o     <= 1'b0;
`ifdef WB_BUS_SCHEDULER_WATCHDOG_EN
            wd_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|m_cyc_i) begin
                        state      <= BUSY;
                        gnt_idx    <= next_idx;
                        last_grant <= next_idx;
                        gnt_o      <= N'(1) << next_idx;
                        busy_o     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (!m_cyc_i[gnt_idx]) begin
                        state  <= IDLE;
                        gnt_o  <= '0;
                        busy_o <= 1'b0;
`ifdef WB_BUS_SCHEDULER_WATCHDOG_EN
                        wd_cnt <= '0;
                    end else if (stall) begin
                        // Reaching the limit this cycle aborts; an ack/err here would have cleared stall.
                        if (wd_cnt == 16'(TIMEOUT-1)) begin
                            state  <= ABORT;
                            wd_cnt <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + 16'd1;
                        end
                    end else begin
                        wd_cnt <= '0;
`endif
                    end
                end
`ifdef WB_BUS_SCHEDULER_WATCHDOG_EN
                ABORT: state <= RELEASE;
                RELEASE: begin
                    if (!m_cyc_i[gnt_idx]) begin
                        state  <= IDLE;
                        gnt_o  <= '0;
                        busy_o <= 1'b0;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
